time_controller: RTL and testbench

TIME_CONTROLLER -- requirements
Module: time_controller

---
 rtl/time_controller_pkg.sv | 26 ++
 rtl/time_controller.sv | 165 ++++++++++++++++
 tb/tb_time_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/time_controller_pkg.sv
// -----------------------------------------------------------------------------
// time_controller_pkg
// Shared types for the timeline controller: the command opcode encoding and
// the controller state encoding.
// -----------------------------------------------------------------------------
package time_controller_pkg;

    // Command opcodes carried on cmd_op. Encodings 6 and 7 are illegal.
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_START  = 3'd2,
        OP_PAUSE  = 3'd3,
        OP_RESUME = 3'd4,
        OP_CLEAR  = 3'd5
    } op_e;

    // Timeline controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_PAUSED  = 2'd3
    } state_e;

endpackage : time_controller_pkg

// File: rtl/time_controller.sv
// -----------------------------------------------------------------------------
// time_controller
// Master timeline for a bank of DAC controllers. A command interface loads the
// timeline, arms a delayed start, pauses/resumes and clears it. When an armed
// start delay expires the block emits a one-cycle auto_start pulse and the
// timeline counter begins incrementing on the following edge.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-high reset
//   cmd_valid  : command present on cmd_op/cmd_data
//   cmd_op     : opcode (see time_controller_pkg::op_e)
//   cmd_data   : LOAD value or START delay
//   cmd_ready  : always 1, every valid command is consumed at the edge
//   counter    : timeline value fanned out to every DAC controller
//   auto_start : one-cycle pulse when the timeline starts
//   running    : state is RUNNING
//   armed      : state is ARMED
//   wrapped    : sticky, the timeline counter rolled over to zero
//   cmd_error  : sticky, an illegal or out-of-state command was seen
// -----------------------------------------------------------------------------
module time_controller
    import time_controller_pkg::*;
#(
    parameter int COUNTER_WIDTH = 64,
    parameter int DELAY_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd_op,
    input  logic [63:0]              cmd_data,
    output logic                     cmd_ready,
    output logic [COUNTER_WIDTH-1:0] counter,
    output logic                     auto_start,
    output logic                     running,
    output logic                     armed,
    output logic                     wrapped,
    output logic                     cmd_error
);

    state_e                   state_q,      state_d;
    logic [COUNTER_WIDTH-1:0] counter_q,    counter_d;
    logic [DELAY_WIDTH-1:0]   delay_q,      delay_d;
    logic                     auto_start_q, auto_start_d;
    logic                     wrapped_q,    wrapped_d;
    logic                     cmd_error_q,  cmd_error_d;

    op_e  op_w;
    logic load_ok_w;
    logic unused_cmd_data;

    assign op_w      = op_e'(cmd_op);
    // LOAD and START are only meaningful while the timeline is stopped.
    assign load_ok_w = (state_q == ST_IDLE) || (state_q == ST_PAUSED);

    // Only the low bits of cmd_data are consumed for narrow configurations.
    assign unused_cmd_data = ^cmd_data;

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        delay_d      = delay_q;
        auto_start_d = 1'b0;
        wrapped_d    = wrapped_q;
        cmd_error_d  = cmd_error_q;

        // Autonomous progress of the timeline, independent of commands.
        case (state_q)
            ST_ARMED: begin
                if (delay_q == '0) begin
                    state_d      = ST_RUNNING;
                    auto_start_d = 1'b1;
                end else begin
                    delay_d = delay_q - DELAY_WIDTH'(1);
                end
            end
            ST_RUNNING: begin
                counter_d = counter_q + COUNTER_WIDTH'(1);
                if (&counter_q) begin
                    wrapped_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Commands are judged against the current state, so a command that
        // lands on the ARMED->RUNNING edge is treated as arriving in ARMED.
        // A rejected command only raises cmd_error; the autonomous update
        // above still takes effect.
        if (cmd_valid) begin
            case (op_w)
                OP_NOP: ;
                OP_LOAD: begin
                    if (load_ok_w) begin
                        counter_d = cmd_data[COUNTER_WIDTH-1:0];
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
                OP_START: begin
                    if (load_ok_w) begin
                        state_d = ST_ARMED;
                        delay_d = cmd_data[DELAY_WIDTH-1:0];
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
                OP_PAUSE: begin
                    // The increment computed above is kept, so the counter
                    // freezes at its post-edge value.
                    if (state_q == ST_RUNNING) begin
                        state_d = ST_PAUSED;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
                OP_RESUME: begin
                    if (state_q == ST_PAUSED) begin
                        state_d = ST_RUNNING;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    // Also aborts a pending start: auto_start is forced low.
                    state_d      = ST_IDLE;
                    counter_d    = '0;
                    delay_d      = '0;
                    auto_start_d = 1'b0;
                    wrapped_d    = 1'b0;
                    cmd_error_d  = 1'b0;
                end
                default: cmd_error_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            delay_q      <= '0;
            auto_start_q <= 1'b0;
            wrapped_q    <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            delay_q      <= delay_d;
            auto_start_q <= auto_start_d;
            wrapped_q    <= wrapped_d;
            cmd_error_q  <= cmd_error_d;
        end
    end

    assign cmd_ready  = 1'b1;
    assign counter    = counter_q;
    assign auto_start = auto_start_q;
    assign running    = (state_q == ST_RUNNING);
    assign armed      = (state_q == ST_ARMED);
    assign wrapped    = wrapped_q;
    assign cmd_error  = cmd_error_q;

endmodule : time_controller

// File: tb/tb_time_controller.sv
// -----------------------------------------------------------------------------
// tb_time_controller
// Directed stimulus for time_controller. The stimulus process schedules the
// expected output snapshot for specific clock edges and the expected
// auto_start pulse edges; an independent monitor compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_time_controller;

    localparam logic [2:0] NOP    = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] PAUSE  = 3'd3;
    localparam logic [2:0] RESUME = 3'd4;
    localparam logic [2:0] CLEAR  = 3'd5;
    localparam logic [2:0] ILL7   = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [63:0] cmd_data = 64'd0;
    logic        cmd_ready;
    logic [63:0] counter;
    logic        auto_start;
    logic        running;
    logic        armed;
    logic        wrapped;
    logic        cmd_error;

    time_controller #(
        .COUNTER_WIDTH(64),
        .DELAY_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .counter    (counter),
        .auto_start (auto_start),
        .running    (running),
        .armed      (armed),
        .wrapped    (wrapped),
        .cmd_error  (cmd_error)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [63:0] cnt;
        bit          as;
        bit          run;
        bit          arm;
        bit          wr;
        bit          er;
    } exp_t;

    exp_t exp_q[$];
    int   as_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    exp_t cur;

    task automatic expect_at(input int c, input string n, input logic [63:0] cnt,
                             input bit as, input bit run, input bit arm,
                             input bit wr, input bit er);
        exp_t x;
        x.cyc = c; x.name = n; x.cnt = cnt;
        x.as = as; x.run = run; x.arm = arm; x.wr = wr; x.er = er;
        exp_q.push_back(x);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [63:0] data, output int e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        e         = cyc;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 64'd0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares scheduled snapshots and every auto_start pulse.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            checks++;
            if (cur.cyc != cyc) begin
                errors++;
                $display("FAIL %s: scheduled for cycle %0d but checked at %0d", cur.name, cur.cyc, cyc);
            end else if (counter !== cur.cnt || auto_start !== cur.as || running !== cur.run ||
                         armed !== cur.arm || wrapped !== cur.wr || cmd_error !== cur.er ||
                         cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s @%0d: got cnt=%h as=%b run=%b arm=%b wr=%b err=%b rdy=%b, need cnt=%h as=%b run=%b arm=%b wr=%b err=%b rdy=1",
                         cur.name, cyc, counter, auto_start, running, armed, wrapped, cmd_error, cmd_ready,
                         cur.cnt, cur.as, cur.run, cur.arm, cur.wr, cur.er);
            end
        end
        if (auto_start === 1'b1) begin
            checks++;
            if (as_q.size() == 0) begin
                errors++;
                $display("FAIL auto_start: unexpected pulse at cycle %0d, none pending", cyc);
            end else begin
                int t;
                t = as_q.pop_front();
                if (t != cyc) begin
                    errors++;
                    $display("FAIL auto_start: pulse at cycle %0d, required at %0d", cyc, t);
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0 || as_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d snapshots and %0d pulses still pending, need 0 and 0",
                         exp_q.size(), as_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e0, r, c;

        // Reset state while reset is held.
        @(posedge clk); #1;
        expect_at(cyc, "reset_state", 64'h0, 0, 0, 0, 0, 0);
        wait_until(2);
        reset = 1'b0;

        // LOAD 0x100 then START D=3: pulse at E0+4, counter 0x100 then 0x101.
        cmd(LOAD, 64'h100, e);
        expect_at(e, "load_idle", 64'h100, 0, 0, 0, 0, 0);
        cmd(START, 64'd3, e0);
        expect_at(e0, "start_armed", 64'h100, 0, 0, 1, 0, 0);
        expect_at(e0 + 3, "still_armed", 64'h100, 0, 0, 1, 0, 0);
        expect_at(e0 + 4, "start_pulse", 64'h100, 1, 1, 0, 0, 0);
        expect_at(e0 + 5, "first_incr", 64'h101, 0, 1, 0, 0, 0);
        as_q.push_back(e0 + 4);
        wait_until(e0 + 5);
        cmd(CLEAR, 64'd0, e);
        expect_at(e, "clear1", 64'h0, 0, 0, 0, 0, 0);

        // Wrap: FE, FF, 0, 1 with wrapped sticky from the wrap edge.
        cmd(LOAD, 64'hFFFF_FFFF_FFFF_FFFE, e);
        cmd(START, 64'd0, e0);
        expect_at(e0 + 1, "wrap_fe", 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0, 0, 0);
        expect_at(e0 + 2, "wrap_ff", 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0);
        expect_at(e0 + 3, "wrap_0",  64'h0, 0, 1, 0, 1, 0);
        expect_at(e0 + 4, "wrap_1",  64'h1, 0, 1, 0, 1, 0);
        as_q.push_back(e0 + 1);
        wait_until(e0 + 4);
        cmd(CLEAR, 64'd0, e);
        expect_at(e, "clear_wrapped", 64'h0, 0, 0, 0, 0, 0);

        // PAUSE at counter 0x50 -> holds 0x51, RESUME -> 0x52, no pulse.
        cmd(LOAD, 64'h4E, e);
        cmd(START, 64'd0, e0);
        expect_at(e0 + 1, "pr_start", 64'h4E, 1, 1, 0, 0, 0);
        as_q.push_back(e0 + 1);
        wait_until(e0 + 3);
        cmd(PAUSE, 64'd0, e);
        expect_at(e,      "paused",     64'h51, 0, 0, 0, 0, 0);
        expect_at(e + 5,  "paused_5",   64'h51, 0, 0, 0, 0, 0);
        expect_at(e + 10, "paused_10",  64'h51, 0, 0, 0, 0, 0);
        wait_until(e + 10);
        cmd(RESUME, 64'd0, r);
        expect_at(r,     "resumed",  64'h51, 0, 1, 0, 0, 0);
        expect_at(r + 1, "resume_1", 64'h52, 0, 1, 0, 0, 0);
        expect_at(r + 2, "resume_2", 64'h53, 0, 1, 0, 0, 0);
        wait_until(r + 2);
        cmd(CLEAR, 64'd0, e);

        // START D=100 aborted by CLEAR after 10 cycles: no pulse for 200 cycles.
        cmd(START, 64'd100, e0);
        expect_at(e0, "long_armed", 64'h0, 0, 0, 1, 0, 0);
        wait_until(e0 + 10);
        cmd(CLEAR, 64'd0, c);
        expect_at(c,       "abort_clear", 64'h0, 0, 0, 0, 0, 0);
        expect_at(c + 200, "abort_quiet", 64'h0, 0, 0, 0, 0, 0);
        wait_until(c + 200);

        // LOAD while RUNNING and opcode 7 raise cmd_error; counter keeps going.
        cmd(LOAD, 64'h10, e);
        cmd(START, 64'd0, e0);
        as_q.push_back(e0 + 1);
        expect_at(e0 + 1, "err_start", 64'h10, 1, 1, 0, 0, 0);
        wait_until(e0 + 2);
        cmd(LOAD, 64'h999, e);
        expect_at(e, "load_running", 64'h12, 0, 1, 0, 0, 1);
        cmd(ILL7, 64'd0, e);
        expect_at(e, "illegal_op", 64'h13, 0, 1, 0, 0, 1);
        cmd(CLEAR, 64'd0, e);
        expect_at(e, "clear_error", 64'h0, 0, 0, 0, 0, 0);

        // PAUSE landing on the ARMED->RUNNING edge is an ARMED command.
        cmd(START, 64'd2, e0);
        as_q.push_back(e0 + 3);
        wait_until(e0 + 2);
        cmd(PAUSE, 64'd0, e);
        expect_at(e,     "edge_cmd",   64'h0, 1, 1, 0, 0, 1);
        expect_at(e + 1, "edge_after", 64'h1, 0, 1, 0, 0, 1);
        cmd(NOP, 64'd0, e);
        cmd(CLEAR, 64'd0, e);
        cmd(PAUSE, 64'd0, e);
        expect_at(e, "pause_idle", 64'h0, 0, 0, 0, 0, 1);
        cmd(CLEAR, 64'd0, e);

        // Asynchronous reset while ARMED with D=5: immediate zeros, no pulse later.
        cmd(LOAD, 64'h77, e);
        cmd(START, 64'd5, e0);
        expect_at(e0, "pre_reset_armed", 64'h77, 0, 0, 1, 0, 0);
        wait_until(e0 + 2);
        #1;
        reset = 1'b1;
        expect_at(cyc, "async_reset", 64'h0, 0, 0, 0, 0, 0);
        wait_until(cyc + 2);
        reset = 1'b0;
        expect_at(cyc + 20, "post_reset_quiet", 64'h0, 0, 0, 0, 0, 0);
        wait_until(cyc + 21);

        done = 1'b1;
    end

endmodule : tb_time_controller
